uart_rx_32: RTL and testbench

- UART receiver assembling 1–4 serial bytes into one 32-bit word. Frame format: 8N1, LSB first.
- Receive-side counterpart of the 32-bit UART transmitter; sits between the serial pin and the FIFO write port.
- Bit period and word length (numData) are runtime inputs, so one build serves every baud rate and word size.

---
 rtl/uart_rx_32_pkg.sv | 34 +++
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_rx_32.sv | 218 +++++++++++++++++++++
 tb/tb_uart_rx_32.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_32_pkg.sv
// rtl/uart_rx_32_pkg.sv - shared state encodings and word helpers for the 32-bit UART receiver
package uart_rx_32_pkg;

  typedef enum logic [2:0] {
    s_IDLE    = 3'd0,
    s_START   = 3'd1,
    s_DATA    = 3'd2,
    s_STOP    = 3'd3,
    s_CLEANUP = 3'd4
  } rx_state_e;

  localparam int DEFAULT_TIMEOUT_BITS = 16;

  function automatic logic [2:0] clamp_num(input logic [2:0] n);
    if (n == 3'd0) begin
      return 3'd1;
    end else if (n > 3'd4) begin
      return 3'd4;
    end
    return n;
  endfunction

  function automatic logic [31:0] keep_bytes(input logic [31:0] w, input logic [2:0] n);
    logic [31:0] m;
    case (n)
      3'd1:    m = 32'h0000_00FF;
      3'd2:    m = 32'h0000_FFFF;
      3'd3:    m = 32'h00FF_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return w & m;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - reset-to-idle (high) synchronizer chain for the asynchronous serial input
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic i_D,
  output logic o_Q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_D};
    end
  end

  assign o_Q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_32.sv
// rtl/uart_rx_32.sv - 8N1 UART receiver packing 1-4 bytes per 32-bit word, LSB byte first
// Optional partial-word flush on idle line: define UART_RX_TIMEOUT_EN.
module uart_rx_32
  import uart_rx_32_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int TIMEOUT_BITS = DEFAULT_TIMEOUT_BITS
) (
  input  logic        i_Clock,
  input  logic        i_Rst_n,
  input  logic        i_Rx_Serial,
  input  logic [11:0] CLKS_PER_BIT,
  input  logic [2:0]  numData,
  output logic        o_Rx_DV,
  output logic [31:0] o_Rx_Word,
  output logic        o_Rx_Active,
  output logic        o_Rx_Frame_Err
);

  if (SYNC_STAGES < 2 || TIMEOUT_BITS < 1) begin : g_param_check
    $error("uart_rx_32: SYNC_STAGES must be >= 2 and TIMEOUT_BITS >= 1");
  end

  rx_state_e   state_q, state_d;
  logic [11:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [2:0]  num_l_q, num_l_d;
  logic [7:0]  shift_q, shift_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] word_q, word_d;
  logic        dv_q, dv_d;
  logic        active_q, active_d;
  logic        ferr_q, ferr_d;
  logic        rx_prev_q;

  logic        rx_s;
  logic        fall;
  logic [11:0] cpb_m1;
  logic [11:0] half_bit;
  logic [2:0]  num_m1;
  logic [1:0]  last_idx;
  logic [31:0] asm_new;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_Clock (i_Clock),
    .i_Rst_n (i_Rst_n),
    .i_D     (i_Rx_Serial),
    .o_Q     (rx_s)
  );

  assign cpb_m1   = CLKS_PER_BIT - 12'd1;
  assign half_bit = cpb_m1 >> 1;
  assign fall     = rx_prev_q & ~rx_s;
  assign num_m1   = num_l_q - 3'd1;
  assign last_idx = num_m1[1:0];

`ifdef UART_RX_TIMEOUT_EN
  logic [31:0] idle_cnt_q, idle_cnt_d;
  logic [31:0] timeout_limit;

  assign timeout_limit = 32'(TIMEOUT_BITS) * {20'd0, CLKS_PER_BIT};

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`endif

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= s_IDLE;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_cnt_q <= '0;
      num_l_q    <= 3'd1;
      shift_q    <= '0;
      asm_q      <= '0;
      word_q     <= '0;
      dv_q       <= 1'b0;
      active_q   <= 1'b0;
      ferr_q     <= 1'b0;
      rx_prev_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_cnt_q <= byte_cnt_d;
      num_l_q    <= num_l_d;
      shift_q    <= shift_d;
      asm_q      <= asm_d;
      word_q     <= word_d;
      dv_q       <= dv_d;
      active_q   <= active_d;
      ferr_q     <= ferr_d;
      rx_prev_q  <= rx_s;
    end
  end

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_cnt_d = byte_cnt_q;
    num_l_d    = num_l_q;
    shift_d    = shift_q;
    asm_d      = asm_q;
    word_d     = word_q;
    dv_d       = 1'b0;
    ferr_d     = 1'b0;
    active_d   = active_q;
    asm_new    = asm_q;
`ifdef UART_RX_TIMEOUT_EN
    idle_cnt_d = '0;
`endif

    case (state_q)
      s_IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        active_d  = 1'b0;
        if (fall) begin
          state_d  = s_START;
          active_d = 1'b1;
          // Word length is frozen at the first byte of each word.
          if (byte_cnt_q == 2'd0) begin
            num_l_d = clamp_num(numData);
          end
        end
`ifdef UART_RX_TIMEOUT_EN
        else if (byte_cnt_q != 2'd0) begin
          if (idle_cnt_q >= timeout_limit) begin
            word_d     = keep_bytes(asm_q, num_l_q);
            dv_d       = 1'b1;
            byte_cnt_d = '0;
            asm_d      = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 32'd1;
          end
        end
`endif
      end

      s_START: begin
        if (clk_cnt_q == half_bit) begin
          clk_cnt_d = '0;
          if (!rx_s) begin
            state_d = s_DATA;
          end else begin
            state_d  = s_IDLE;
            active_d = 1'b0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 12'd1;
        end
      end

      s_DATA: begin
        if (clk_cnt_q == cpb_m1) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
            state_d = s_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 12'd1;
        end
      end

      s_STOP: begin
        if (clk_cnt_q == cpb_m1) begin
          clk_cnt_d = '0;
          active_d  = 1'b0;
          if (rx_s) begin
            state_d = s_CLEANUP;
          end else begin
            // A broken frame poisons the whole word in progress.
            ferr_d     = 1'b1;
            byte_cnt_d = '0;
            asm_d      = '0;
            state_d    = s_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 12'd1;
        end
      end

      s_CLEANUP: begin
        asm_new[{byte_cnt_q, 3'b000} +: 8] = shift_q;
        if (byte_cnt_q == last_idx) begin
          word_d     = keep_bytes(asm_new, num_l_q);
          dv_d       = 1'b1;
          byte_cnt_d = '0;
          asm_d      = '0;
        end else begin
          asm_d      = asm_new;
          byte_cnt_d = byte_cnt_q + 2'd1;
        end
        state_d = s_IDLE;
      end

      default: begin
        state_d = s_IDLE;
      end
    endcase
  end

  assign o_Rx_DV        = dv_q;
  assign o_Rx_Word      = word_q;
  assign o_Rx_Active    = active_q;
  assign o_Rx_Frame_Err = ferr_q;

endmodule

// File: tb/tb_uart_rx_32.sv
// tb/tb_uart_rx_32.sv - directed and randomized self-checking bench for uart_rx_32
module tb_uart_rx_32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic [11:0] cpb;
  logic [2:0]  num;
  logic        dv;
  logic [31:0] word;
  logic        active;
  logic        ferr;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          ferr_cnt = 0;
  logic [31:0] dv_words[$];

  always #5 clk = ~clk;

  uart_rx_32 dut (
    .i_Clock        (clk),
    .i_Rst_n        (rst_n),
    .i_Rx_Serial    (rx),
    .CLKS_PER_BIT   (cpb),
    .numData        (num),
    .o_Rx_DV        (dv),
    .o_Rx_Word      (word),
    .o_Rx_Active    (active),
    .o_Rx_Frame_Err (ferr)
  );

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (dv === 1'b1) dv_words.push_back(word);
      if (ferr === 1'b1) ferr_cnt++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int nbits);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rx = fr[i];
      repeat (int'(cpb)) @(negedge clk);
    end
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * int'(cpb)) @(negedge clk);
  endtask

  function automatic int eff_len(input int n);
    if (n == 0) return 1;
    if (n > 4) return 4;
    return n;
  endfunction

  // Reference: bytes arrive LSB-first and fill the word from byte 0 upward.
  function automatic logic [31:0] model_word(input logic [7:0] b[4], input int n);
    logic [31:0] w;
    w = 0;
    for (int i = 0; i < eff_len(n); i++) w = w + (32'(b[i]) << (8 * i));
    return w;
  endfunction

  task automatic send_word(input logic [7:0] b[4], input int n);
    for (int i = 0; i < eff_len(n); i++) send_frame(b[i], 1'b1, 10);
    idle_bits(2);
  endtask

  task automatic expect_word(input string tag, input logic [31:0] exp);
    int sz;
    sz = dv_words.size();
    chk({tag, "_dv_count"}, 32'(sz), 32'd1);
    if (sz != 0) chk(tag, dv_words[0], exp);
    dv_words.delete();
  endtask

  initial begin
    logic [7:0] b[4];
    int n;

    rst_n = 1'b0;
    rx    = 1'b1;
    cpb   = 12'd87;
    num   = 3'd4;
    repeat (3) @(negedge clk);
    chk("reset_dv", {31'd0, dv}, 32'd0);
    chk("reset_word", word, 32'd0);
    chk("reset_active", {31'd0, active}, 32'd0);
    chk("reset_ferr", {31'd0, ferr}, 32'd0);
    rst_n = 1'b1;
    idle_bits(1);

    b = '{8'h78, 8'h56, 8'h34, 8'h12};
    send_word(b, 4);
    expect_word("word4", model_word(b, 4));

    num = 3'd2;
    b = '{8'hAB, 8'hCD, 8'hEE, 8'hFF};
    send_word(b, 2);
    expect_word("word2", model_word(b, 2));

    num = 3'd1;
    b = '{8'h5A, 8'h00, 8'h00, 8'h00};
    send_word(b, 1);
    expect_word("word1", model_word(b, 1));

    rx = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_active_early", {31'd0, active}, 32'd1);
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (50) @(negedge clk);
    chk("glitch_active_late", {31'd0, active}, 32'd0);
    idle_bits(1);
    chk("glitch_no_dv", 32'(dv_words.size()), 32'd0);
    b = '{8'h3C, 8'h00, 8'h00, 8'h00};
    send_word(b, 1);
    expect_word("after_glitch", model_word(b, 1));

    num = 3'd4;
    send_frame(8'h11, 1'b1, 10);
    send_frame(8'h22, 1'b0, 10);
    idle_bits(2);
    chk("ferr_pulses", 32'(ferr_cnt), 32'd1);
    chk("ferr_no_dv", 32'(dv_words.size()), 32'd0);
    b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send_word(b, 4);
    expect_word("after_ferr", model_word(b, 4));

    send_frame(8'h01, 1'b1, 10);
    send_frame(8'h02, 1'b1, 10);
    send_frame(8'h03, 1'b1, 5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_dv", {31'd0, dv}, 32'd0);
    chk("midrst_word", word, 32'd0);
    chk("midrst_active", {31'd0, active}, 32'd0);
    chk("midrst_ferr", {31'd0, ferr}, 32'd0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_bits(1);
    chk("midrst_no_dv", 32'(dv_words.size()), 32'd0);
    b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_word(b, 4);
    expect_word("after_rst", model_word(b, 4));

    for (int t = 0; t < 12; t++) begin
      cpb = 12'($urandom_range(40, 4));
      n   = int'($urandom_range(7, 0));
      num = 3'(n);
      for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
      idle_bits(1);
      send_word(b, n);
      expect_word($sformatf("rand%0d_cpb%0d_n%0d", t, cpb, n), model_word(b, n));
    end
    chk("total_ferr", 32'(ferr_cnt), 32'd1);

`ifdef UART_RX_TIMEOUT_EN
    cpb = 12'd87;
    num = 3'd4;
    idle_bits(1);
    send_frame(8'h11, 1'b1, 10);
    send_frame(8'h22, 1'b1, 10);
    idle_bits(14);
    chk("timeout_early_no_dv", 32'(dv_words.size()), 32'd0);
    idle_bits(4);
    expect_word("timeout_flush", 32'h0000_2211);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
